// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic ops plus a multi-cycle
// unsigned remainder computed by restoring division, one bit per cycle.
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             carry,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_XOR = 3'b010;
    localparam logic [2:0] SEL_NOR = 3'b011;
    localparam logic [2:0] SEL_LT  = 3'b100;
    localparam logic [2:0] SEL_ADD = 3'b101;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_MOD = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] op_res;
    logic             op_carry;
    logic             op_dz;
    logic             mod_start;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;

    // Single-cycle result for every op; MOD here only covers the b == 0 case.
    always_comb begin
        sum_w    = {1'b0, a} + {1'b0, b};
        diff_w   = {1'b0, a} - {1'b0, b};
        op_res   = '0;
        op_carry = 1'b0;
        op_dz    = 1'b0;
        case (sel)
            SEL_AND: op_res = a & b;
            SEL_OR:  op_res = a | b;
            SEL_XOR: op_res = a ^ b;
            SEL_NOR: op_res = ~(a | b);
            SEL_LT:  op_res = WIDTH'(diff_w[WIDTH]);
            SEL_ADD: begin
                op_res   = sum_w[WIDTH-1:0];
                op_carry = sum_w[WIDTH];
            end
            SEL_SUB: begin
                op_res   = diff_w[WIDTH-1:0];
                op_carry = diff_w[WIDTH];
            end
            SEL_MOD: begin
                op_res = a;
                op_dz  = 1'b1;
            end
            default: op_res = '0;
        endcase
    end

    assign mod_start = (sel == SEL_MOD) && (b != '0);

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted  = {rem, dvd[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            res      <= '0;
            zero     <= 1'b1;
            carry    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mod_start) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            rem   <= '0;
                            dvd   <= a;
                            dvs   <= b;
                        end else begin
                            res      <= op_res;
                            zero     <= (op_res == '0);
                            carry    <= op_carry;
                            div_zero <= op_dz;
                            done     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    // Remainder is only published on the final step.
                    if (cnt == CNT_LAST) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        res      <= rem_next;
                        zero     <= (rem_next == '0);
                        carry    <= 1'b0;
                        div_zero <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
